instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0, the byte address of the first fetch after reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 1024, the instruction memory size in bytes; it is a power of two.
REQ-003 SHALL have parameter DEPTH, default 2, the prefetch FIFO entry count; it is a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit, a synchronous active-low reset (0 = reset, sampled on posedge clk).
REQ-006 SHALL have port address, output, 64 bits, the byte address to instruction memory; equals the current fetch PC.
REQ-007 SHALL have port instruction, input, 32 bits, combinational read data from memory for address.
REQ-008 SHALL have port redirect, input, 1 bit, a branch/jump redirect strobe.
REQ-009 SHALL have port redirect_pc, input, 64 bits, the redirect target byte address.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the FIFO head holds a valid instruction.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the head this cycle.
REQ-012 SHALL have port out_instr, output, 32 bits, the FIFO head instruction.
REQ-013 SHALL have port out_pc, output, 64 bits, the byte address of out_instr.
REQ-014 SHALL have port fault, output, 1 bit, meaning the fetch PC is misaligned or out of bounds and fetching has halted.

Function
REQ-015 SHALL implement states RUN and FAULT; out_valid, out_instr and out_pc come from FIFO registers, with no combinational path from instruction.
REQ-016 SHALL define pop = out_valid & out_ready, and push = (state==RUN) & !redirect & (count<DEPTH | pop).
REQ-017 SHALL write {instruction, pc} into the FIFO tail on push, at the same posedge, and set pc <= pc+4 (64-bit modulo).
REQ-018 SHALL remove the head on pop; simultaneous push and pop at count==DEPTH is legal and leaves count unchanged.
REQ-019 SHALL leave count, pc and FIFO contents unchanged when there is neither push nor pop.
REQ-020 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count register of log2(DEPTH)+1 bits.
REQ-021 SHALL, on redirect=1, take priority over push and pop: FIFO flushed (count=0, pointers=0, out_valid=0 next cycle) and pc <= redirect_pc.
REQ-022 SHALL go to RUN on redirect when redirect_pc[1:0]==0 and redirect_pc+3 < IMEM_SIZE, and to FAULT otherwise; this holds in either state.
REQ-023 SHALL, in RUN with no redirect, go to FAULT and suppress the push when pc[1:0]!=0 or pc+3 >= IMEM_SIZE; pc is held.
REQ-024 SHALL, in FAULT: assert fault=1, perform no pushes, hold pc, continue draining already-buffered entries via pop, and leave only on redirect or reset.
REQ-025 SHALL drive address = pc at all times, including in FAULT.
REQ-026 SHALL give latency of 1 cycle from an address presented to its instruction appearing at out_instr/out_valid.
REQ-027 SHALL sustain a throughput of 1 instruction/cycle while out_ready=1.

Reset
REQ-028 SHALL, when reset==0 at posedge, set: pc=RESET_PC, state=RUN, count=0, pointers=0, out_valid=0, fault=0, out_instr=0, out_pc=0.
REQ-029 SHALL give reset priority over redirect, push and pop; reset mid-stream discards all buffered entries.
REQ-030 SHALL have its first push on the first posedge with reset==1, fetching RESET_PC.

Verification
REQ-031 SHALL cover streaming: reset released with out_ready=1 and mem[i]=i -> out_pc 0,4,8,... with out_instr 0,1,2,... on consecutive cycles, 1/cycle.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles -> count saturates at 2, address holds 8, and out_pc 0,4 are kept; out_ready=1 -> 0,4,8 emitted in order with no gaps or duplicates.
REQ-033 SHALL cover redirect: redirect=1, redirect_pc=0x40 while FIFO is full -> next cycle out_valid=0; the following cycle out_pc=0x40 with out_instr=mem[16].
REQ-034 SHALL cover a misaligned redirect: redirect_pc=0x42 -> fault=1, no pushes, address=0x42; then redirect_pc=0x10 -> fault=0 and out_pc=0x10 one cycle later.
REQ-035 SHALL cover running off the end: RESET_PC=0x3F8 with out_ready=1 -> outputs 0x3F8 and 0x3FC, then fault=1 with pc held at 0x400 and out_valid=0 after drain.
REQ-036 SHALL cover reset mid-operation: reset=0 for one cycle with count=2 -> out_valid=0, fault=0, and the next fetch is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencer feeding a registered prefetch FIFO; fetch-to-out_valid latency is one cycle.
// Backpressure: fetching stalls when the FIFO is full and out_ready is low; a redirect flushes all buffered entries.

module ifu_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdat_i,
  output logic [WIDTH-1:0]       rdat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdat_i;
    end
  end

  assign rdat_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          IMEM_SIZE = 1024,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] address,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);
  typedef enum logic {RUN, FAULT} state_t;

  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_SIZE);

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          push, pop, has_room;
  logic [CW-1:0] count;
  logic [95:0]   head;

  // Widened to 65 bits so a PC near 2^64 cannot wrap into the valid range.
  function automatic logic pc_ok(input logic [63:0] pc);
    return (pc[1:0] == 2'b00) && (({1'b0, pc} + 65'd3) < IMEM_LIMIT);
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign has_room  = (count < CW'(DEPTH)) | pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = pc_ok(redirect_pc) ? RUN : FAULT;
    end else if (state_q == RUN) begin
      if (!pc_ok(pc_q)) begin
        state_d = FAULT;
      end else if (has_room) begin
        push = 1'b1;
        pc_d = pc_q + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifu_fifo #(
    .WIDTH (96),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdat_i  ({instruction, pc_q}),
    .rdat_o  (head),
    .count_o (count)
  );

  assign address   = pc_q;
  assign fault     = (state_q == FAULT);
  assign out_instr = head[95:64];
  assign out_pc    = head[63:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: DUT A fetches from address 0, DUT B starts near the end of memory.
// Accepted outputs are compared against per-DUT queues of expected {pc, instruction}.

module tb_instr_fetch_unit;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, redirect_a, out_ready_a, out_valid_a, fault_a;
  logic [63:0] redirect_pc_a, address_a, out_pc_a;
  logic [31:0] instruction_a, out_instr_a;
  logic        rst_b, redirect_b, out_ready_b, out_valid_b, fault_b;
  logic [63:0] redirect_pc_b, address_b, out_pc_b;
  logic [31:0] instruction_b, out_instr_b;

  int   checks = 0;
  int   passed = 0;
  logic sb_en_a = 1'b0;
  logic sb_en_b = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t mon_a, mon_b;

  // Memory image: word i holds i; anything past 1 KiB reads as a marker value.
  assign instruction_a = (address_a < 64'd1024) ? address_a[33:2] : 32'hDEAD_BEEF;
  assign instruction_b = (address_b < 64'd1024) ? address_b[33:2] : 32'hDEAD_BEEF;

  instr_fetch_unit #(.RESET_PC(64'd0), .IMEM_SIZE(1024), .DEPTH(2)) dut_a (
    .clk(clk), .reset(rst_a), .address(address_a), .instruction(instruction_a),
    .redirect(redirect_a), .redirect_pc(redirect_pc_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_instr(out_instr_a), .out_pc(out_pc_a), .fault(fault_a));

  instr_fetch_unit #(.RESET_PC(64'h3F8), .IMEM_SIZE(1024), .DEPTH(2)) dut_b (
    .clk(clk), .reset(rst_b), .address(address_b), .instruction(instruction_b),
    .redirect(redirect_b), .redirect_pc(redirect_pc_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_instr(out_instr_b), .out_pc(out_pc_b), .fault(fault_b));

  function automatic exp_t mk(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc[33:2];
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb_en_a && out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        $display("FAIL sb_a_extra: got pc=%h instr=%h, expected no output", out_pc_a, out_instr_a);
      end else begin
        mon_a = exp_a.pop_front();
        if (out_pc_a !== mon_a.pc || out_instr_a !== mon_a.instr)
          $display("FAIL sb_a_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc_a, out_instr_a, mon_a.pc, mon_a.instr);
        else passed++;
      end
    end
  end

  always @(negedge clk) begin
    if (sb_en_b && out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        $display("FAIL sb_b_extra: got pc=%h instr=%h, expected no output", out_pc_b, out_instr_b);
      end else begin
        mon_b = exp_b.pop_front();
        if (out_pc_b !== mon_b.pc || out_instr_b !== mon_b.instr)
          $display("FAIL sb_b_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc_b, out_instr_b, mon_b.pc, mon_b.instr);
        else passed++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++; if (out_valid_a !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid_a); else passed++;
    checks++; if (fault_a !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault_a); else passed++;
    checks++; if (address_a !== 64'd0) $display("FAIL rst_addr_a: got %h want 0", address_a); else passed++;
    checks++; if (out_instr_a !== 32'd0) $display("FAIL rst_instr: got %h want 0", out_instr_a); else passed++;
    checks++; if (out_pc_a !== 64'd0) $display("FAIL rst_pc: got %h want 0", out_pc_a); else passed++;
    checks++; if (address_b !== 64'h3F8) $display("FAIL rst_addr_b: got %h want 3f8", address_b); else passed++;
    rst_a = 1'b1;
    cyc();
    checks++; if (out_valid_a !== 1'b1) $display("FAIL first_valid: got %b want 1", out_valid_a); else passed++;
    checks++; if (out_pc_a !== 64'd0) $display("FAIL first_pc: got %h want 0", out_pc_a); else passed++;
    checks++; if (address_a !== 64'd4) $display("FAIL first_addr: got %h want 4", address_a); else passed++;
  endtask

  task automatic test_stream();
    sb_en_a = 1'b0; out_ready_a = 1'b0; redirect_a = 1'b0; rst_a = 1'b0;
    cyc();
    rst_a = 1'b1; out_ready_a = 1'b1; sb_en_a = 1'b1;
    for (int k = 0; k < 8; k++) exp_a.push_back(mk(64'(4 * k)));
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++; if (out_valid_a !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid_a); else passed++;
      checks++; if (address_a !== 64'(4 * (k + 1))) $display("FAIL stream_addr[%0d]: got %h want %h", k, address_a, 4 * (k + 1)); else passed++;
    end
    cyc();
    sb_en_a = 1'b0; out_ready_a = 1'b0;
    checks++; if (exp_a.size() != 0) $display("FAIL stream_left: got %0d pending want 0", exp_a.size()); else passed++;
  endtask

  task automatic test_backpressure();
    sb_en_a = 1'b0; out_ready_a = 1'b0; redirect_a = 1'b0; rst_a = 1'b0;
    cyc();
    rst_a = 1'b1; sb_en_a = 1'b1;
    for (int k = 0; k < 4; k++) exp_a.push_back(mk(64'(4 * k)));
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++; if (address_a !== ((i == 1) ? 64'd4 : 64'd8)) $display("FAIL bp_addr[%0d]: got %h", i, address_a); else passed++;
      checks++; if (out_pc_a !== 64'd0 || out_valid_a !== 1'b1) $display("FAIL bp_head[%0d]: got pc=%h v=%b want pc=0 v=1", i, out_pc_a, out_valid_a); else passed++;
    end
    out_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (out_valid_a !== 1'b1) $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, out_valid_a); else passed++;
    end
    sb_en_a = 1'b0; out_ready_a = 1'b0;
    checks++; if (exp_a.size() != 0) $display("FAIL bp_left: got %0d pending want 0", exp_a.size()); else passed++;
  endtask

  task automatic test_redirect();
    sb_en_a = 1'b0; out_ready_a = 1'b0; redirect_a = 1'b0; rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    cyc(); cyc();
    checks++; if (address_a !== 64'd8) $display("FAIL redir_full_addr: got %h want 8", address_a); else passed++;
    exp_a.push_back(mk(64'h40));
    exp_a.push_back(mk(64'h44));
    sb_en_a = 1'b1; redirect_a = 1'b1; redirect_pc_a = 64'h40;
    cyc();
    redirect_a = 1'b0; out_ready_a = 1'b1;
    checks++; if (out_valid_a !== 1'b0) $display("FAIL redir_flush: got valid %b want 0", out_valid_a); else passed++;
    checks++; if (address_a !== 64'h40) $display("FAIL redir_addr: got %h want 40", address_a); else passed++;
    cyc();
    checks++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'h40 || out_instr_a !== 32'd16)
      $display("FAIL redir_first: got v=%b pc=%h instr=%h want v=1 pc=40 instr=10", out_valid_a, out_pc_a, out_instr_a); else passed++;
    cyc(); cyc();
    sb_en_a = 1'b0; out_ready_a = 1'b0;
    checks++; if (exp_a.size() != 0) $display("FAIL redir_left: got %0d pending want 0", exp_a.size()); else passed++;
  endtask

  task automatic test_misaligned();
    sb_en_a = 1'b0; out_ready_a = 1'b0; redirect_a = 1'b0; rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    cyc();
    redirect_a = 1'b1; redirect_pc_a = 64'h42;
    cyc();
    redirect_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (fault_a !== 1'b1 || out_valid_a !== 1'b0 || address_a !== 64'h42)
        $display("FAIL mis_fault[%0d]: got f=%b v=%b addr=%h want f=1 v=0 addr=42", i, fault_a, out_valid_a, address_a); else passed++;
      cyc();
    end
    redirect_a = 1'b1; redirect_pc_a = 64'h10; out_ready_a = 1'b1; sb_en_a = 1'b1;
    exp_a.push_back(mk(64'h10));
    cyc();
    redirect_a = 1'b0;
    checks++; if (fault_a !== 1'b0 || address_a !== 64'h10) $display("FAIL mis_recover: got f=%b addr=%h want f=0 addr=10", fault_a, address_a); else passed++;
    cyc();
    checks++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'h10) $display("FAIL mis_first: got v=%b pc=%h want v=1 pc=10", out_valid_a, out_pc_a); else passed++;
    cyc();
    sb_en_a = 1'b0; out_ready_a = 1'b0;
    checks++; if (exp_a.size() != 0) $display("FAIL mis_left: got %0d pending want 0", exp_a.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    sb_en_a = 1'b0; out_ready_a = 1'b0; redirect_a = 1'b0; rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    cyc(); cyc();
    checks++; if (out_valid_a !== 1'b1) $display("FAIL mid_full: got valid %b want 1", out_valid_a); else passed++;
    rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    checks++; if (out_valid_a !== 1'b0 || fault_a !== 1'b0 || address_a !== 64'd0)
      $display("FAIL mid_reset: got v=%b f=%b addr=%h want v=0 f=0 addr=0", out_valid_a, fault_a, address_a); else passed++;
    cyc();
    checks++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'd0 || address_a !== 64'd4)
      $display("FAIL mid_refetch: got v=%b pc=%h addr=%h want v=1 pc=0 addr=4", out_valid_a, out_pc_a, address_a); else passed++;
    redirect_a = 1'b1; redirect_pc_a = 64'h42;
    cyc();
    redirect_a = 1'b0;
    checks++; if (fault_a !== 1'b1) $display("FAIL mid_fault_set: got %b want 1", fault_a); else passed++;
    rst_a = 1'b0; redirect_a = 1'b1; redirect_pc_a = 64'h80;
    cyc();
    rst_a = 1'b1; redirect_a = 1'b0;
    checks++; if (fault_a !== 1'b0 || address_a !== 64'd0 || out_valid_a !== 1'b0)
      $display("FAIL mid_rst_prio: got f=%b addr=%h v=%b want f=0 addr=0 v=0", fault_a, address_a, out_valid_a); else passed++;
  endtask

  task automatic test_run_off_end();
    out_ready_b = 1'b1; sb_en_b = 1'b1;
    exp_b.push_back(mk(64'h3F8));
    exp_b.push_back(mk(64'h3FC));
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (fault_b !== 1'b0 || out_valid_b !== 1'b1 || address_b !== 64'(64'h3FC + 4 * i))
        $display("FAIL end_run[%0d]: got f=%b v=%b addr=%h", i, fault_b, out_valid_b, address_b); else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (fault_b !== 1'b1 || out_valid_b !== 1'b0 || address_b !== 64'h400)
        $display("FAIL end_fault[%0d]: got f=%b v=%b addr=%h want f=1 v=0 addr=400", i, fault_b, out_valid_b, address_b); else passed++;
    end
    sb_en_b = 1'b0; out_ready_b = 1'b0;
    checks++; if (exp_b.size() != 0) $display("FAIL end_left: got %0d pending want 0", exp_b.size()); else passed++;
  endtask

  task automatic test_fault_drain();
    sb_en_b = 1'b0; out_ready_b = 1'b0; rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    cyc(); cyc(); cyc();
    checks++; if (fault_b !== 1'b1 || out_valid_b !== 1'b1 || out_pc_b !== 64'h3F8 || address_b !== 64'h400)
      $display("FAIL drain_hold: got f=%b v=%b pc=%h addr=%h want f=1 v=1 pc=3f8 addr=400", fault_b, out_valid_b, out_pc_b, address_b); else passed++;
    exp_b.push_back(mk(64'h3F8));
    exp_b.push_back(mk(64'h3FC));
    out_ready_b = 1'b1; sb_en_b = 1'b1;
    cyc(); cyc();
    checks++; if (out_valid_b !== 1'b0 || fault_b !== 1'b1) $display("FAIL drain_empty: got v=%b f=%b want v=0 f=1", out_valid_b, fault_b); else passed++;
    sb_en_b = 1'b0; out_ready_b = 1'b0;
    checks++; if (exp_b.size() != 0) $display("FAIL drain_left: got %0d pending want 0", exp_b.size()); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = 64'd0; out_ready_a = 1'b0;
    rst_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 64'd0; out_ready_b = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_reset_mid();
    test_run_off_end();
    test_fault_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
